wb_ram_slave: RTL and testbench

// Parametrised Wishbone B4 slave in front of a single-port synchronous RAM; next generation of
// the classic 16-bit RAM slave. Configurable data width, depth and wait states, byte-lane

---
 rtl/wb_ram_slave_pkg.sv | 21 ++
 rtl/wb_ram_slave_if.sv | 37 +++
 rtl/wb_ram_slave_ram_be.sv | 43 ++++
 rtl/wb_ram_slave.sv | 159 +++++++++++++++
 tb/tb_wb_ram_slave.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_slave_pkg
// Description : Shared types and helpers for the Wishbone RAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_ram_slave_pkg;

  // Cycle flavour the slave speaks on the bus
  typedef enum logic {
    WB_CLASSIC   = 1'b0,
    WB_PIPELINED = 1'b1
  } wb_mode_e;

  // Number of byte lanes for a given data width
  function automatic int sel_w(input int dw);
    return dw / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_slave_if
// Description : Wishbone B4 bus bundle between a master and the RAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_ram_slave_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  import wb_ram_slave_pkg::*;

  localparam int c_SW = sel_w(DW);

  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [c_SW-1:0] wb_sel_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_stall_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_ram_slave_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_slave_ram_be
// Description : Single-port synchronous RAM with byte enables (ram_be).
//               Read data is registered on i_en; writes go lane by lane.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_slave_ram_be
  import wb_ram_slave_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 65536
) (
  input  wire logic                     clk,
  input  wire logic                     i_en,
  input  wire logic [sel_w(DW)-1:0]     i_be,
  input  wire logic [$clog2(DEPTH)-1:0] i_addr,
  input  wire logic [DW-1:0]            i_wdata,
  output logic      [DW-1:0]            o_rdata
);

  localparam int c_SW = sel_w(DW);

  logic [DW-1:0] r_mem [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated
  always_ff @(posedge clk) begin
    for (int b = 0; b < c_SW; b++) begin
      if (i_be[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; returns the row contents from before a same-edge write
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_slave
// Description : Wishbone B4 slave in front of a byte-enable synchronous RAM.
//               Classic or pipelined cycles, WAIT extra wait states, up to
//               MAX_OUT requests in flight when pipelined.
//               Optional macro WB_ERR_EN: out-of-range addresses terminate
//               with err instead of aliasing onto the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 16,
  parameter int DEPTH     = 65536,
  parameter int WAIT      = 0,
  parameter int PIPELINED = 0,
  parameter int MAX_OUT   = 4
) (
  input wire logic      clk,
  input wire logic      rst_n,
  wb_ram_slave_if.slave bus
);

  localparam int       c_SW   = sel_w(DW);
  localparam int       c_RW   = $clog2(DEPTH);
  localparam int       c_CW   = $clog2(MAX_OUT + 1);
  localparam wb_mode_e c_MODE = (PIPELINED != 0) ? WB_PIPELINED : WB_CLASSIC;

  // Delay-line control flags; index 0 is loaded at accept, index WAIT is the head
  logic [WAIT:0]   r_vld;
  logic [WAIT:0]   r_we;
  logic [WAIT:0]   r_err;
  logic [c_CW-1:0] r_count;

  logic            w_accept;
  logic            w_stall;
  logic            w_oor;
  logic            w_wr_en;
  logic            w_head_vld;
  logic            w_ack;
  logic            w_err;
  logic [c_SW-1:0] w_be;
  logic [c_RW-1:0] w_row;
  logic [DW-1:0]   w_ram_rdata;
  logic [DW-1:0]   w_head_dat;

  assign w_row = bus.wb_adr_i[c_RW-1:0];

`ifdef WB_ERR_EN
  // Any set bit above the RAM row bits means the address is beyond DEPTH
  if (AW > c_RW) begin : g_range
    assign w_oor = |bus.wb_adr_i[AW-1:c_RW];
  end else begin : g_no_range
    assign w_oor = 1'b0;
  end
`else
  // Upper address bits are ignored so the RAM aliases across the address space
  logic w_unused_adr;
  assign w_unused_adr = ^bus.wb_adr_i;
  assign w_oor        = 1'b0;
`endif

  if (c_MODE == WB_PIPELINED) begin : g_pipe
    // Back-pressure once the in-flight window is full
    assign w_stall  = (r_count == c_CW'(MAX_OUT));
    assign w_accept = bus.wb_cyc_i & bus.wb_stb_i & ~w_stall;
  end else begin : g_classic
    // One transfer at a time; the ack cycle itself also blocks a new accept
    logic w_busy;
    assign w_busy   = (r_count != '0);
    assign w_stall  = 1'b0;
    assign w_accept = bus.wb_cyc_i & bus.wb_stb_i & ~w_ack & ~w_busy;
  end

  // Out-of-range writes must not touch the RAM, and sel=0 writes nothing
  assign w_wr_en = w_accept & bus.wb_we_i & ~w_oor;
  assign w_be    = w_wr_en ? bus.wb_sel_i : '0;

  wb_ram_slave_ram_be #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_accept),
    .i_be    (w_be),
    .i_addr  (w_row),
    .i_wdata (bus.wb_dat_i),
    .o_rdata (w_ram_rdata)
  );

  // Shift request flags toward the head; dropping cyc aborts everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_we  <= '0;
      r_err <= '0;
    end else if (!bus.wb_cyc_i) begin
      r_vld <= '0;
      r_we  <= '0;
      r_err <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_we[0]  <= bus.wb_we_i;
      r_err[0] <= w_oor;
      for (int i = 1; i <= WAIT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_we[i]  <= r_we[i-1];
        r_err[i] <= r_err[i-1];
      end
    end
  end

  // The RAM output register is the first data stage; later stages follow it
  if (WAIT == 0) begin : g_no_dly
    assign w_head_dat = w_ram_rdata;
  end else begin : g_dly
    logic [DW-1:0] r_dly [1:WAIT];

    // Carry read data alongside its flags so it reaches the head with them
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i <= WAIT; i++) begin
          r_dly[i] <= '0;
        end
      end else begin
        r_dly[1] <= w_ram_rdata;
        for (int i = 2; i <= WAIT; i++) begin
          r_dly[i] <= r_dly[i-1];
        end
      end
    end

    assign w_head_dat = r_dly[WAIT];
  end

  assign w_head_vld = r_vld[WAIT];
  assign w_ack      = w_head_vld & ~r_err[WAIT];
  assign w_err      = w_head_vld &  r_err[WAIT];

  // Requests in flight: up on accept, down on termination, cleared on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!bus.wb_cyc_i) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_CW'(w_accept) - c_CW'(w_head_vld);
    end
  end

  assign bus.wb_ack_o   = w_ack;
  assign bus.wb_err_o   = w_err;
  assign bus.wb_stall_o = w_stall;
  assign bus.wb_dat_o   = (w_ack && !r_we[WAIT]) ? w_head_dat : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ram_slave
// Description : Directed bench: a classic WAIT=0 slave and a pipelined
//               WAIT=2 MAX_OUT=3 slave, both DEPTH=1024, on a shared clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ram_slave;
  import wb_ram_slave_pkg::*;

  localparam int c_DW    = 32;
  localparam int c_AW    = 16;
  localparam int c_DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_ram_slave_if #(.DW(c_DW), .AW(c_AW)) bus_c ();
  wb_ram_slave_if #(.DW(c_DW), .AW(c_AW)) bus_p ();

  wb_ram_slave #(
    .DW(c_DW), .AW(c_AW), .DEPTH(c_DEPTH), .WAIT(0), .PIPELINED(0), .MAX_OUT(1)
  ) u_cls (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  wb_ram_slave #(
    .DW(c_DW), .AW(c_AW), .DEPTH(c_DEPTH), .WAIT(2), .PIPELINED(1), .MAX_OUT(3)
  ) u_pip (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_p)
  );

  // Single classic transfer; lat counts edges from the accept edge (1 = accept edge)
  task automatic cls_xfer(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output logic [31:0] rdat,
                          output int lat, output logic [1:0] term);
    lat  = -1;
    rdat = '0;
    term = 2'b00;
    bus_c.wb_cyc_i = 1'b1; bus_c.wb_stb_i = 1'b1; bus_c.wb_we_i = we;
    bus_c.wb_adr_i = adr;  bus_c.wb_sel_i = sel;  bus_c.wb_dat_i = dat;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus_c.wb_ack_o || bus_c.wb_err_o) begin
        lat  = k;
        rdat = bus_c.wb_dat_o;
        term = {bus_c.wb_err_o, bus_c.wb_ack_o};
      end
    end
    bus_c.wb_cyc_i = 1'b0; bus_c.wb_stb_i = 1'b0; bus_c.wb_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Single pipelined transfer; strobe is held for exactly the accept edge
  task automatic pip_xfer(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output logic [31:0] rdat,
                          output int lat, output logic [1:0] term);
    lat  = -1;
    rdat = '0;
    term = 2'b00;
    bus_p.wb_cyc_i = 1'b1; bus_p.wb_stb_i = 1'b1; bus_p.wb_we_i = we;
    bus_p.wb_adr_i = adr;  bus_p.wb_sel_i = sel;  bus_p.wb_dat_i = dat;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus_p.wb_stb_i = 1'b0;
      if (bus_p.wb_ack_o || bus_p.wb_err_o) begin
        lat  = k;
        rdat = bus_p.wb_dat_o;
        term = {bus_p.wb_err_o, bus_p.wb_ack_o};
      end
    end
    bus_p.wb_cyc_i = 1'b0; bus_p.wb_stb_i = 1'b0; bus_p.wb_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pipelined read burst from base; records accept/ack edges, data and stall per cycle
  task automatic pip_burst(input int n, input logic [15:0] base,
                           output int acc_e [5], output int ack_e [5],
                           output logic [31:0] ack_d [5],
                           output logic [15:0] stall_map, output int nack);
    int   req;
    logic acc_now;
    req = 0; nack = 0; stall_map = '0;
    for (int i = 0; i < 5; i++) begin
      acc_e[i] = -1; ack_e[i] = -1; ack_d[i] = '0;
    end
    bus_p.wb_cyc_i = 1'b1; bus_p.wb_stb_i = 1'b1; bus_p.wb_we_i = 1'b0;
    bus_p.wb_sel_i = 4'hF; bus_p.wb_adr_i = base;
    for (int t = 1; t <= 14; t++) begin
      acc_now = bus_p.wb_stb_i && !bus_p.wb_stall_o;
      if (acc_now && req < 5) acc_e[req] = t;
      @(posedge clk); #1;
      if (acc_now) req++;
      bus_p.wb_stb_i = (req < n);
      bus_p.wb_adr_i = base + 16'(req);
      if (bus_p.wb_stall_o) stall_map[t] = 1'b1;
      if (bus_p.wb_ack_o) begin
        if (nack < 5) begin
          ack_e[nack] = t;
          ack_d[nack] = bus_p.wb_dat_o;
        end
        nack++;
      end
    end
    bus_p.wb_cyc_i = 1'b0; bus_p.wb_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({bus_c.wb_ack_o, bus_c.wb_err_o, bus_c.wb_stall_o, bus_c.wb_dat_o} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_cls got ack=%b err=%b stall=%b dat=%h exp all 0",
               bus_c.wb_ack_o, bus_c.wb_err_o, bus_c.wb_stall_o, bus_c.wb_dat_o);
    end
    n_checks++;
    if ({bus_p.wb_ack_o, bus_p.wb_err_o, bus_p.wb_stall_o, bus_p.wb_dat_o} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_pip got ack=%b err=%b stall=%b dat=%h exp all 0",
               bus_p.wb_ack_o, bus_p.wb_err_o, bus_p.wb_stall_o, bus_p.wb_dat_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_classic_rw();
    logic [31:0] rd; int lat; logic [1:0] term;
    cls_xfer(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, rd, lat, term);
    n_checks++;
    if (lat != 1 || term !== 2'b01 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL cls_write got lat=%0d term=%b dat=%h exp lat=1 term=01 dat=0", lat, term, rd);
    end
    cls_xfer(1'b0, 16'h0010, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (lat != 1 || term !== 2'b01) begin
      n_fail++;
      $display("FAIL cls_read_lat got lat=%0d term=%b exp lat=1 term=01", lat, term);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL cls_read_dat got %h exp deadbeef", rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; logic [1:0] term;
    cls_xfer(1'b1, 16'h0020, 4'hF, 32'h11223344, rd, lat, term);
    cls_xfer(1'b1, 16'h0020, 4'h5, 32'hAABBCCDD, rd, lat, term);
    cls_xfer(1'b0, 16'h0020, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL byte_lanes got %h exp 11bb33dd", rd);
    end
    cls_xfer(1'b1, 16'h0020, 4'h0, 32'hFFFFFFFF, rd, lat, term);
    n_checks++;
    if (lat != 1 || term !== 2'b01) begin
      n_fail++;
      $display("FAIL sel0_ack got lat=%0d term=%b exp lat=1 term=01", lat, term);
    end
    cls_xfer(1'b0, 16'h0020, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL sel0_nowrite got %h exp 11bb33dd", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ack_map;
    logic [31:0] first_dat;
    ack_map = '0;
    first_dat = '0;
    bus_c.wb_cyc_i = 1'b1; bus_c.wb_stb_i = 1'b1; bus_c.wb_we_i = 1'b0;
    bus_c.wb_adr_i = 16'h0010; bus_c.wb_sel_i = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      ack_map[k] = bus_c.wb_ack_o;
      if (k == 0) first_dat = bus_c.wb_dat_o;
    end
    bus_c.wb_cyc_i = 1'b0; bus_c.wb_stb_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ack_map !== 6'b010101) begin
      n_fail++;
      $display("FAIL b2b_ack_pattern got %b exp 010101", ack_map);
    end
    n_checks++;
    if (first_dat !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL b2b_dat got %h exp deadbeef", first_dat);
    end
  endtask

  task automatic test_raw();
    int ack_e [2]; logic [31:0] ack_d [2]; int nack;
    nack = 0;
    ack_e[0] = -1; ack_e[1] = -1; ack_d[0] = '0; ack_d[1] = '0;
    bus_p.wb_cyc_i = 1'b1; bus_p.wb_stb_i = 1'b1; bus_p.wb_we_i = 1'b1;
    bus_p.wb_adr_i = 16'h0030; bus_p.wb_sel_i = 4'hF; bus_p.wb_dat_i = 32'h5A5A1234;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      if (t == 1) bus_p.wb_we_i  = 1'b0;
      if (t == 2) bus_p.wb_stb_i = 1'b0;
      if (bus_p.wb_ack_o && nack < 2) begin
        ack_e[nack] = t; ack_d[nack] = bus_p.wb_dat_o; nack++;
      end
    end
    bus_p.wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ack_e[0] != 3 || ack_e[1] != 4) begin
      n_fail++;
      $display("FAIL raw_ack_edges got %0d,%0d exp 3,4", ack_e[0], ack_e[1]);
    end
    n_checks++;
    if (ack_d[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL raw_write_dat got %h exp 0", ack_d[0]);
    end
    n_checks++;
    if (ack_d[1] !== 32'h5A5A1234) begin
      n_fail++;
      $display("FAIL raw_read_dat got %h exp 5a5a1234", ack_d[1]);
    end
  endtask

  task automatic test_pipelined();
    logic [31:0] rd; int lat; logic [1:0] term;
    int acc_e [5]; int ack_e [5]; logic [31:0] ack_d [5]; logic [15:0] smap; int nack;
    int exp_acc [5] = '{1, 2, 3, 5, 6};
    int exp_ack [5] = '{3, 4, 5, 7, 8};
    for (int i = 0; i < 5; i++) begin
      pip_xfer(1'b1, 16'h0040 + 16'(i), 4'hF, 32'hA0000040 + 32'(i), rd, lat, term);
    end
    n_checks++;
    if (lat != 3 || term !== 2'b01) begin
      n_fail++;
      $display("FAIL pip_write got lat=%0d term=%b exp lat=3 term=01", lat, term);
    end
    pip_burst(5, 16'h0040, acc_e, ack_e, ack_d, smap, nack);
    n_checks++;
    if (smap !== 16'h0008) begin
      n_fail++;
      $display("FAIL pip_stall_map got %h exp 0008", smap);
    end
    n_checks++;
    if (nack != 5) begin
      n_fail++;
      $display("FAIL pip_ack_count got %0d exp 5", nack);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (acc_e[i] != exp_acc[i] || ack_e[i] != exp_ack[i]) begin
        n_fail++;
        $display("FAIL pip_timing[%0d] got acc=%0d ack=%0d exp acc=%0d ack=%0d",
                 i, acc_e[i], ack_e[i], exp_acc[i], exp_ack[i]);
      end
      n_checks++;
      if (ack_d[i] !== 32'hA0000040 + 32'(i)) begin
        n_fail++;
        $display("FAIL pip_dat[%0d] got %h exp %h", i, ack_d[i], 32'hA0000040 + 32'(i));
      end
    end
  endtask

  task automatic test_abort();
    int acc_e [5]; int ack_e [5]; logic [31:0] ack_d [5]; logic [15:0] smap; int nack;
    int stray;
    int exp_acc [3] = '{1, 2, 3};
    int exp_ack [3] = '{3, 4, 5};
    stray = 0;
    bus_p.wb_cyc_i = 1'b1; bus_p.wb_stb_i = 1'b1; bus_p.wb_we_i = 1'b0;
    bus_p.wb_sel_i = 4'hF; bus_p.wb_adr_i = 16'h0041;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      if (t == 1) bus_p.wb_adr_i = 16'h0042;
      if (t == 2) begin
        bus_p.wb_cyc_i = 1'b0; bus_p.wb_stb_i = 1'b0;
      end
      if (bus_p.wb_ack_o || bus_p.wb_err_o) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL abort_no_ack got %0d terminations exp 0", stray);
    end
    pip_burst(3, 16'h0042, acc_e, ack_e, ack_d, smap, nack);
    n_checks++;
    if (smap !== 16'h0008 || nack != 3) begin
      n_fail++;
      $display("FAIL abort_count_clear got stall_map=%h acks=%0d exp 0008 3", smap, nack);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (acc_e[i] != exp_acc[i] || ack_e[i] != exp_ack[i] ||
          ack_d[i] !== 32'hA0000042 + 32'(i)) begin
        n_fail++;
        $display("FAIL abort_after[%0d] got acc=%0d ack=%0d dat=%h exp acc=%0d ack=%0d dat=%h",
                 i, acc_e[i], ack_e[i], ack_d[i], exp_acc[i], exp_ack[i],
                 32'hA0000042 + 32'(i));
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; int lat; logic [1:0] term;
    cls_xfer(1'b1, 16'h0000, 4'hF, 32'h01234567, rd, lat, term);
    cls_xfer(1'b1, 16'h0400, 4'hF, 32'hCAFEF00D, rd, lat, term);
`ifdef WB_ERR_EN
    n_checks++;
    if (lat != 1 || term !== 2'b10) begin
      n_fail++;
      $display("FAIL range_wr_err got lat=%0d term=%b exp lat=1 term=10", lat, term);
    end
    cls_xfer(1'b0, 16'h0400, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (term !== 2'b10 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL range_rd_err got term=%b dat=%h exp term=10 dat=0", term, rd);
    end
    cls_xfer(1'b0, 16'h0000, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (term !== 2'b01 || rd !== 32'h01234567) begin
      n_fail++;
      $display("FAIL range_row0 got term=%b dat=%h exp term=01 dat=01234567", term, rd);
    end
`else
    n_checks++;
    if (lat != 1 || term !== 2'b01) begin
      n_fail++;
      $display("FAIL alias_wr_ack got lat=%0d term=%b exp lat=1 term=01", lat, term);
    end
    cls_xfer(1'b0, 16'h0400, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (term !== 2'b01 || rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL alias_rd_hi got term=%b dat=%h exp term=01 dat=cafef00d", term, rd);
    end
    cls_xfer(1'b0, 16'h0000, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (term !== 2'b01 || rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL alias_row0 got term=%b dat=%h exp term=01 dat=cafef00d", term, rd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic [1:0] term;
    bus_p.wb_cyc_i = 1'b1; bus_p.wb_stb_i = 1'b1; bus_p.wb_we_i = 1'b0;
    bus_p.wb_sel_i = 4'hF; bus_p.wb_adr_i = 16'h0040;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if ({bus_p.wb_ack_o, bus_p.wb_stall_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_pre got ack=%b stall=%b exp 1 1", bus_p.wb_ack_o, bus_p.wb_stall_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_p.wb_ack_o, bus_p.wb_err_o, bus_p.wb_stall_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_async_flags got ack=%b err=%b stall=%b exp 0 0 0",
               bus_p.wb_ack_o, bus_p.wb_err_o, bus_p.wb_stall_o);
    end
    n_checks++;
    if (bus_p.wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_async_dat got %h exp 0", bus_p.wb_dat_o);
    end
    bus_p.wb_cyc_i = 1'b0; bus_p.wb_stb_i = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pip_xfer(1'b1, 16'h0050, 4'hF, 32'h600DCAFE, rd, lat, term);
    pip_xfer(1'b0, 16'h0050, 4'hF, 32'h0, rd, lat, term);
    n_checks++;
    if (lat != 3 || term !== 2'b01 || rd !== 32'h600DCAFE) begin
      n_fail++;
      $display("FAIL mid_post got lat=%0d term=%b dat=%h exp lat=3 term=01 dat=600dcafe",
               lat, term, rd);
    end
  endtask

  // Safety net so the run always ends even if the DUT wedges a wait
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_c.wb_cyc_i = 1'b0; bus_c.wb_stb_i = 1'b0; bus_c.wb_we_i = 1'b0;
    bus_c.wb_adr_i = '0;   bus_c.wb_sel_i = '0;   bus_c.wb_dat_i = '0;
    bus_p.wb_cyc_i = 1'b0; bus_p.wb_stb_i = 1'b0; bus_p.wb_we_i = 1'b0;
    bus_p.wb_adr_i = '0;   bus_p.wb_sel_i = '0;   bus_p.wb_dat_i = '0;
    test_reset();
    test_classic_rw();
    test_byte_lanes();
    test_back_to_back();
    test_raw();
    test_pipelined();
    test_abort();
    test_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
